// File: rtl/mc_pkg.sv
// Shared types and helpers for the multi-channel pulse-train generator.
package mc_pkg;

  typedef enum logic [1:0] {
    ST_PULSE,
    ST_GAP,
    ST_TAIL
  } mc_state_e;

  function automatic int unsigned mc_neutral(
    input int unsigned lo,
    input int unsigned hi
  );
    return (lo + hi) / 2;
  endfunction

endpackage

// File: rtl/mc_slew_limiter.sv
// One channel: clamps an accepted target into a shadow register and
// slews the live width toward it by at most STEP per commit.
module mc_slew_limiter
  import mc_pkg::*;
#(
  parameter int CW     = 21,
  parameter int PW_MIN = 100000,
  parameter int PW_MAX = 200000,
  parameter int STEP   = 1000
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [CW-1:0] target,
  input  logic          load,
  input  logic          commit,
  output logic [CW-1:0] cur_width
);

  localparam logic [CW:0] LO  = (CW+1)'(PW_MIN);
  localparam logic [CW:0] HI  = (CW+1)'(PW_MAX);
  localparam logic [CW:0] STP = (CW+1)'(STEP);
  localparam logic [CW:0] NEU = (CW+1)'(mc_neutral(PW_MIN, PW_MAX));

  logic [CW:0] tgt_w;
  logic [CW:0] clamp;
  logic [CW:0] diff;
  logic [CW:0] shadow_q, shadow_d;
  logic [CW:0] cur_q, cur_d;

  assign tgt_w = {1'b0, target};

  always_comb begin
    clamp = tgt_w;
    if (tgt_w < LO) begin
      clamp = LO;
    end else if (tgt_w > HI) begin
      clamp = HI;
    end
    shadow_d = load ? clamp : shadow_q;
  end

  // One extra bit keeps cur+STEP and the differences free of wrap.
  always_comb begin
    cur_d = cur_q;
    diff  = '0;
    if (commit) begin
      if (shadow_q > cur_q) begin
        diff  = shadow_q - cur_q;
        cur_d = (diff > STP) ? cur_q + STP : shadow_q;
      end else if (shadow_q < cur_q) begin
        diff  = cur_q - shadow_q;
        cur_d = (diff > STP) ? cur_q - STP : shadow_q;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow_q <= NEU;
      cur_q    <= NEU;
    end else begin
      shadow_q <= shadow_d;
      cur_q    <= cur_d;
    end
  end

  assign cur_width = cur_q[CW-1:0];

endmodule

// File: rtl/mc_pulse_train.sv
// Frame counter, channel sequencer FSM and serial PWM output for
// NCH time-multiplexed servo/ESC channels.
module mc_pulse_train
  import mc_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int CW     = 21,
  parameter int FRAME  = 1100000,
  parameter int GAP    = 110000,
  parameter int PW_MIN = 100000,
  parameter int PW_MAX = 200000,
  parameter int STEP   = 1000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NCH*CW-1:0] target,
  input  logic              target_valid,
  output logic              target_ready,
  output logic              PWM,
  output logic              frame_start,
  output logic [NCH*CW-1:0] cur_width
);

  localparam int FW  = $clog2(FRAME);
  localparam int GW  = $clog2(GAP + 1);
  localparam int PCW = (CW > GW) ? CW : GW;
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [FW-1:0]  LAST    = FW'(FRAME - 1);
  localparam logic [PCW-1:0] GAP_END = PCW'(GAP - 1);
  localparam logic [CHW-1:0] CH_LAST = CHW'(NCH - 1);

  if (NCH < 1 || NCH > 8) begin : g_bad_nch
    $error("mc_pulse_train: NCH out of range");
  end
  if (longint'(NCH) * (longint'(PW_MAX) + GAP) >= FRAME) begin : g_bad_frame
    $error("mc_pulse_train: channels do not fit in FRAME");
  end
  if (PW_MIN > PW_MAX) begin : g_bad_pw
    $error("mc_pulse_train: PW_MIN > PW_MAX");
  end
  if (STEP == 0) begin : g_bad_step
    $error("mc_pulse_train: STEP must be nonzero");
  end
  if (PW_MIN < 1 || GAP < 1) begin : g_bad_min
    $error("mc_pulse_train: PW_MIN and GAP must be at least 1");
  end
  if (longint'(PW_MAX) >= (longint'(1) << CW)) begin : g_bad_cw
    $error("mc_pulse_train: PW_MAX does not fit in CW bits");
  end

  // run_q holds the frame at cycle 0 until the first edge after reset.
  logic           run_q;
  logic [FW-1:0]  cnt_q, cnt_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [CHW-1:0] ch_q, ch_d;
  mc_state_e      state_q, state_d;

  logic           commit;
  logic           load;
  logic [CW-1:0]  w_cur;
  logic [CW-1:0]  w_arr [2**CHW];

  assign target_ready = run_q & (cnt_q != LAST);
  assign frame_start  = run_q & (cnt_q == '0);
  assign PWM          = run_q & (state_q == ST_PULSE);
  assign commit       = run_q & (cnt_q == LAST);
  assign load         = target_valid & target_ready;

  for (genvar g = 0; g < 2**CHW; g++) begin : g_ch
    if (g < NCH) begin : g_lim
      mc_slew_limiter #(
        .CW     (CW),
        .PW_MIN (PW_MIN),
        .PW_MAX (PW_MAX),
        .STEP   (STEP)
      ) u_lim (
        .CLK       (CLK),
        .RST       (RST),
        .target    (target[g*CW +: CW]),
        .load      (load),
        .commit    (commit),
        .cur_width (w_arr[g])
      );
      assign cur_width[g*CW +: CW] = w_arr[g];
    end else begin : g_pad
      assign w_arr[g] = '0;
    end
  end

  assign w_cur = w_arr[ch_q];

  always_comb begin
    cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + FW'(1);
    state_d = state_q;
    ch_d    = ch_q;
    pc_d    = pc_q + PCW'(1);
    unique case (state_q)
      ST_PULSE: begin
        if (pc_q == PCW'(w_cur) - PCW'(1)) begin
          state_d = ST_GAP;
          pc_d    = '0;
        end
      end
      ST_GAP: begin
        if (pc_q == GAP_END) begin
          pc_d = '0;
          if (ch_q == CH_LAST) begin
            state_d = ST_TAIL;
          end else begin
            ch_d    = ch_q + CHW'(1);
            state_d = ST_PULSE;
          end
        end
      end
      ST_TAIL: begin
        pc_d = '0;
        if (cnt_q == LAST) begin
          state_d = ST_PULSE;
          ch_d    = '0;
        end
      end
      default: begin
        state_d = ST_PULSE;
        ch_d    = '0;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      pc_q    <= '0;
      ch_q    <= '0;
      state_q <= ST_PULSE;
    end else begin
      run_q <= 1'b1;
      if (run_q) begin
        cnt_q   <= cnt_d;
        pc_q    <= pc_d;
        ch_q    <= ch_d;
        state_q <= state_d;
      end
    end
  end

endmodule

// File: tb/tb_mc_pulse_train.sv
// Directed bench for mc_pulse_train: frame timing, slew, clamp,
// handshake latency and asynchronous reset.
module tb_mc_pulse_train;

  localparam int NCH   = 2;
  localparam int CW    = 21;
  localparam int FRAME = 1000;
  localparam int GAP   = 50;
  localparam int PWMIN = 100;
  localparam int PWMAX = 200;
  localparam int STEP  = 10;

  logic              CLK;
  logic              RST;
  logic              tv;
  logic              tr;
  logic              pwm;
  logic              fs;
  logic [NCH*CW-1:0] tgt;
  logic [NCH*CW-1:0] cw;

  int n_chk = 0;
  int n_bad = 0;
  int pos   = 0;

  mc_pulse_train #(
    .NCH    (NCH),
    .CW     (CW),
    .FRAME  (FRAME),
    .GAP    (GAP),
    .PW_MIN (PWMIN),
    .PW_MAX (PWMAX),
    .STEP   (STEP)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .target       (tgt),
    .target_valid (tv),
    .target_ready (tr),
    .PWM          (pwm),
    .frame_start  (fs),
    .cur_width    (cw)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag,
                          input logic [63:0] got,
                          input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] wv(input int w0, input int w1);
    logic [NCH*CW-1:0] v;
    v = {CW'(w1), CW'(w0)};
    return 64'(v);
  endfunction

  task automatic tick();
    logic acc;
    acc = tv && tr;
    @(posedge CLK);
    #1;
    if (acc) tv = 1'b0;
    pos = (pos + 1) % FRAME;
  endtask

  task automatic do_reset(input string tag);
    tv  = 1'b0;
    RST = 1'b1;
    #1;
    check_eq({tag, "_pwm"}, 64'(pwm), 0);
    check_eq({tag, "_fs"}, 64'(fs), 0);
    check_eq({tag, "_rdy"}, 64'(tr), 0);
    repeat (2) @(posedge CLK);
    #1;
    check_eq({tag, "_width"}, 64'(cw), wv(150, 150));
    RST = 1'b0;
    #1;
    check_eq({tag, "_fs_rel"}, 64'(fs), 0);
    @(posedge CLK);
    #1;
    pos = 0;
    check_eq({tag, "_fs_c0"}, 64'(fs), 1);
    check_eq({tag, "_pwm_c0"}, 64'(pwm), 1);
  endtask

  // One full frame against the model; optionally offer a target at sp.
  task automatic run_frame(input string tag,
                           input int w0, input int w1,
                           input int sp, input int t0, input int t1);
    int   ep, ef, er, ew;
    logic xp;
    ep = 0; ef = 0; er = 0; ew = 0;
    for (int c = 0; c < FRAME; c++) begin
      xp = (pos < w0) || (pos >= w0 + GAP && pos < w0 + GAP + w1);
      if (pwm !== xp) ep++;
      if (fs !== (pos == 0)) ef++;
      if (tr !== (pos != FRAME - 1)) er++;
      if (64'(cw) !== wv(w0, w1)) ew++;
      if (pos == sp) begin
        tgt = {CW'(t1), CW'(t0)};
        tv  = 1'b1;
      end
      tick();
    end
    check_eq({tag, "_pwm"}, 64'(ep), 0);
    check_eq({tag, "_fs"}, 64'(ef), 0);
    check_eq({tag, "_rdy"}, 64'(er), 0);
    check_eq({tag, "_width"}, 64'(ew), 0);
  endtask

  initial begin
    RST = 1'b1;
    tv  = 1'b0;
    tgt = '0;

    do_reset("rst0");
    run_frame("f0", 150, 150, 10, 200, 150);
    run_frame("f1", 160, 150, -1, 0, 0);
    run_frame("f2", 170, 150, -1, 0, 0);
    run_frame("f3", 180, 150, -1, 0, 0);
    run_frame("f4", 190, 150, -1, 0, 0);
    run_frame("f5", 200, 150, -1, 0, 0);
    run_frame("f6", 200, 150, -1, 0, 0);

    do_reset("rst1");
    run_frame("c0", 150, 150, 20, 50, 250);
    run_frame("c1", 140, 160, -1, 0, 0);
    run_frame("c2", 130, 170, -1, 0, 0);
    run_frame("c3", 120, 180, -1, 0, 0);
    run_frame("c4", 110, 190, -1, 0, 0);
    run_frame("c5", 100, 200, -1, 0, 0);
    run_frame("c6", 100, 200, -1, 0, 0);

    repeat (75) tick();
    check_eq("mid_pwm", 64'(pwm), 1);
    check_eq("mid_width", 64'(cw), wv(100, 200));
    do_reset("rst2");
    run_frame("r0", 150, 150, -1, 0, 0);

    run_frame("l0", 150, 150, FRAME - 1, 150, 155);
    run_frame("l1", 150, 150, -1, 0, 0);
    run_frame("l2", 150, 155, -1, 0, 0);
    run_frame("l3", 150, 155, -1, 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
